// File: rtl/prbs7_checker.sv
// PRBS7 (x^7+x^6+1) receive checker: self-syncs, locks, then counts bit errors
// against a free-running local generator, with windowed loss-of-lock.
module prbs7_checker #(
  parameter int LOCK_COUNT = 14,
  parameter int ERR_WIN    = 32,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int PW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [MW-1:0] LC_M1   = MW'(LOCK_COUNT - 1);
  localparam logic [PW-1:0] WP_LAST = PW'(ERR_WIN - 1);
  localparam logic [EW-1:0] TH_M1   = EW'(ERR_THRESH - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_SEARCH,
    S_LOCKED
  } state_t;

  state_t           r_state, w_state_n;
  logic [6:0]       r_hist, w_hist_n;
  logic [2:0]       r_fill, w_fill_n;
  logic [MW-1:0]    r_match, w_match_n;
  logic [PW-1:0]    r_win_pos, w_win_pos_n;
  logic [EW-1:0]    r_win_err, w_win_err_n;
  logic             r_bit_err, w_bit_err_n;
  logic [CNT_W-1:0] r_err_count, w_err_count_n;

  logic w_pred;
  logic w_mis;
  logic w_wrap;

  assign w_pred = r_hist[6] ^ r_hist[5];
  assign w_mis  = data_in ^ w_pred;
  assign w_wrap = (r_win_pos == WP_LAST);

  always_comb begin
    w_state_n     = r_state;
    w_hist_n      = r_hist;
    w_fill_n      = r_fill;
    w_match_n     = r_match;
    w_win_pos_n   = r_win_pos;
    w_win_err_n   = r_win_err;
    w_bit_err_n   = 1'b0;
    w_err_count_n = r_err_count;
    if (enable) begin
      case (r_state)
        S_FILL: begin
          w_hist_n = {r_hist[5:0], data_in};
          if (r_fill == 3'd6) begin
            w_state_n = S_SEARCH;
            w_fill_n  = '0;
            w_match_n = '0;
          end else begin
            w_fill_n = r_fill + 3'd1;
          end
        end
        S_SEARCH: begin
          w_hist_n = {r_hist[5:0], data_in};
          // an all-zero history is the LFSR lock-up state, never a match
          if (!w_mis && (r_hist != 7'd0)) begin
            if (r_match == LC_M1) begin
              w_state_n   = S_LOCKED;
              w_match_n   = '0;
              w_win_pos_n = '0;
              w_win_err_n = '0;
            end else begin
              w_match_n = r_match + 1'b1;
            end
          end else begin
            w_match_n = '0;
          end
        end
        S_LOCKED: begin
          w_hist_n    = {r_hist[5:0], w_pred};
          w_win_pos_n = w_wrap ? '0 : r_win_pos + 1'b1;
          if (w_wrap) w_win_err_n = '0;
          if (w_mis) begin
            w_bit_err_n = 1'b1;
            if (r_err_count != '1) w_err_count_n = r_err_count + 1'b1;
            if (r_win_err == TH_M1) begin
              w_state_n   = S_FILL;
              w_hist_n    = '0;
              w_fill_n    = '0;
              w_match_n   = '0;
              w_win_pos_n = '0;
              w_win_err_n = '0;
            end else if (!w_wrap) begin
              w_win_err_n = r_win_err + 1'b1;
            end
          end
        end
        default: begin
          w_state_n = S_FILL;
          w_hist_n  = '0;
          w_fill_n  = '0;
          w_match_n = '0;
        end
      endcase
    end
    // clear is a command, honoured even on idle cycles
    if (clear_cnt) w_err_count_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_pos   <= '0;
      r_win_err   <= '0;
      r_bit_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_n;
      r_hist      <= w_hist_n;
      r_fill      <= w_fill_n;
      r_match     <= w_match_n;
      r_win_pos   <= w_win_pos_n;
      r_win_err   <= w_win_err_n;
      r_bit_err   <= w_bit_err_n;
      r_err_count <= w_err_count_n;
    end
  end

  assign locked    = (r_state == S_LOCKED);
  assign bit_err   = r_bit_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs7_checker.sv
// Scoreboard bench for prbs7_checker: a behavioural model queues expected
// outputs per accepted edge; scenario tasks add directed checks.
module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        data_in = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  prbs7_checker #(
    .LOCK_COUNT(14),
    .ERR_WIN(32),
    .ERR_THRESH(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .data_in(data_in),
    .clear_cnt(clear_cnt),
    .locked(locked),
    .bit_err(bit_err),
    .err_count(err_count)
  );

  typedef struct packed {
    logic        lk;
    logic        be;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [6:0]  g;
  int          m_state;
  logic [6:0]  m_hist;
  int          m_nfill, m_nmatch, m_pos, m_werr;
  logic        m_berr;
  logic [15:0] m_cnt;

  function automatic logic gen_bit();
    g = {g[5:0], g[6] ^ g[5]};
    return g[0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_hist = '0; m_nfill = 0; m_nmatch = 0;
    m_pos = 0; m_werr = 0; m_berr = 1'b0; m_cnt = '0;
  endtask

  task automatic model_step(input logic en, input logic d, input logic clr);
    logic p;
    p = m_hist[6] ^ m_hist[5];
    m_berr = 1'b0;
    if (en) begin
      if (m_state == 0) begin
        m_hist = {m_hist[5:0], d};
        m_nfill++;
        if (m_nfill == 7) begin m_state = 1; m_nmatch = 0; m_nfill = 0; end
      end else if (m_state == 1) begin
        if (d == p && m_hist != 7'd0) m_nmatch++;
        else m_nmatch = 0;
        m_hist = {m_hist[5:0], d};
        if (m_nmatch == 14) begin
          m_state = 2; m_pos = 0; m_werr = 0; m_nmatch = 0;
        end
      end else begin
        m_hist = {m_hist[5:0], p};
        if (d != p) begin
          m_berr = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt++;
          m_werr++;
        end
        if (m_werr == 4) begin
          m_state = 0; m_hist = '0; m_pos = 0; m_werr = 0; m_nfill = 0;
        end else begin
          m_pos++;
          if (m_pos == 32) begin m_pos = 0; m_werr = 0; end
        end
      end
    end
    if (clr) m_cnt = '0;
  endtask

  task automatic step(input logic en, input logic d, input logic clr);
    exp_t e;
    enable = en; data_in = d; clear_cnt = clr;
    model_step(en, d, clr);
    e.lk = (m_state == 2); e.be = m_berr; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (locked !== e.lk) begin
      errors++; $display("FAIL sb_locked got %b exp %b t=%0t", locked, e.lk, $time);
    end
    checks++;
    if (bit_err !== e.be) begin
      errors++; $display("FAIL sb_bit_err got %b exp %b t=%0t", bit_err, e.be, $time);
    end
    checks++;
    if (err_count !== e.cnt) begin
      errors++; $display("FAIL sb_err_count got %0d exp %0d t=%0t", err_count, e.cnt, $time);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    enable = 1'b0; clear_cnt = 1'b0;
    reset = 1'b1; #1;
    model_reset();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", locked); end
    checks++;
    if (bit_err !== 1'b0) begin errors++; $display("FAIL rst_bit_err got %b exp 0", bit_err); end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock(input string tag);
    logic saw_be;
    saw_be = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      step(1'b1, gen_bit(), 1'b0);
      saw_be |= bit_err;
      if (i == 20) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL %s_early got %b exp 0", tag, locked); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL %s_locked got %b exp 1", tag, locked); end
    checks++;
    if (saw_be !== 1'b0) begin errors++; $display("FAIL %s_no_bit_err got %b exp 0", tag, saw_be); end
  endtask

  task automatic test_single_err();
    logic [15:0] c0;
    c0 = err_count;
    step(1'b1, ~gen_bit(), 1'b0);
    checks++;
    if (bit_err !== 1'b1) begin errors++; $display("FAIL single_pulse got %b exp 1", bit_err); end
    checks++;
    if (err_count !== c0 + 16'd1) begin
      errors++; $display("FAIL single_count got %0d exp %0d", err_count, c0 + 16'd1);
    end
    step(1'b1, gen_bit(), 1'b0);
    checks++;
    if (bit_err !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %b exp 0", bit_err); end
    for (int i = 0; i < 126; i++) step(1'b1, gen_bit(), 1'b0);
    checks++;
    if (err_count !== c0 + 16'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL single_clean got %0d/%b exp %0d/1", err_count, locked, c0 + 16'd1);
    end
  endtask

  task automatic test_loss();
    step(1'b1, gen_bit(), 1'b1);
    while (m_pos != 2) step(1'b1, gen_bit(), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ~gen_bit(), 1'b0);
      if (i == 2) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL loss_early got %b exp 1", locked); end
      end
    end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL loss_unlock got %b exp 0", locked); end
    checks++;
    if (err_count !== 16'd4) begin errors++; $display("FAIL loss_count got %0d exp 4", err_count); end
    checks++;
    if (bit_err !== 1'b1) begin errors++; $display("FAIL loss_pulse got %b exp 1", bit_err); end
    test_lock("relock");
  endtask

  task automatic test_three_per_window();
    logic [15:0] c0;
    logic        dropped;
    c0 = err_count;
    dropped = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (m_pos == 5 || m_pos == 10 || m_pos == 15) step(1'b1, ~gen_bit(), 1'b0);
      else step(1'b1, gen_bit(), 1'b0);
      if (locked !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL three_win_drop got %b exp 0", dropped); end
    checks++;
    if (err_count !== c0 + 16'd12) begin
      errors++; $display("FAIL three_win_count got %0d exp %0d", err_count, c0 + 16'd12);
    end
  endtask

  task automatic test_enable_hold();
    logic [15:0] c0;
    c0 = err_count;
    for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    checks++;
    if (err_count !== c0 || locked !== 1'b1) begin
      errors++; $display("FAIL hold_state got %0d/%b exp %0d/1", err_count, locked, c0);
    end
    for (int i = 0; i < 20; i++) step(1'b1, gen_bit(), 1'b0);
    checks++;
    if (err_count !== c0) begin errors++; $display("FAIL hold_resume got %0d exp %0d", err_count, c0); end
  endtask

  task automatic test_clear_and_async();
    step(1'b1, ~gen_bit(), 1'b1);
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL clr_wins got %0d exp 0", err_count); end
    checks++;
    if (bit_err !== 1'b1) begin errors++; $display("FAIL clr_pulse got %b exp 1", bit_err); end
    step(1'b1, ~gen_bit(), 1'b0);
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL clr_after got %0d exp 1", err_count); end
    step(1'b1, gen_bit(), 1'b0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL async_locked got %b exp 0", locked); end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL async_count got %0d exp 0", err_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_no_lock();
    logic any_lock;
    test_reset();
    any_lock = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      any_lock |= locked;
    end
    checks++;
    if (any_lock !== 1'b0) begin errors++; $display("FAIL zeros_lock got %b exp 0", any_lock); end
    for (int i = 0; i < 150; i++) begin
      step(1'b1, (i % 3) != 2, 1'b0);
      any_lock |= locked;
    end
    checks++;
    if (any_lock !== 1'b0) begin errors++; $display("FAIL pattern_lock got %b exp 0", any_lock); end
    test_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    checks++;
    if (err_count !== m_cnt) begin
      errors++; $display("FAIL random_count got %0d exp %0d", err_count, m_cnt);
    end
  endtask

  initial begin
    model_reset();
    g = 7'h7F;
    test_reset();
    test_lock("lock");
    test_single_err();
    test_loss();
    test_three_per_window();
    test_enable_hold();
    test_clear_and_async();
    test_no_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
